// File: rtl/c_result_writer.sv
// Write-back stage for matrix C: buffers MAC results, narrows them to memory width and
// writes them row-major from C_BASE. Define RESULT_SAT_EN to saturate instead of truncate.
module c_result_writer #(
    parameter int          N          = 8,
    parameter int          ACC_W      = 20,
    parameter int          DATA_W     = 16,
    parameter logic [7:0]  C_BASE     = 8'd128,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     Start,
    input  logic                     res_valid,
    input  logic signed [ACC_W-1:0]  res_data,
    output logic                     res_ready,
    input  logic                     mem_gnt,
    output logic                     weC,
    output logic [7:0]               addrC,
    output logic [DATA_W-1:0]        dataC,
    output logic                     Busy,
    output logic                     Done,
    output logic [7:0]               count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = 9;
    localparam logic [CNT_W-1:0] TOTAL     = CNT_W'(N * N);
    localparam logic [PTR_W:0]   OCC_FULL  = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state;
    logic [DATA_W-1:0]     fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wrPtr;
    logic [PTR_W-1:0]      rdPtr;
    logic [PTR_W:0]        occ;
    logic [CNT_W-1:0]      acceptCnt;
    logic [CNT_W-1:0]      wrIdx;
    logic [CNT_W-1:0]      acceptNext;
    logic [CNT_W-1:0]      wrNext;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic [DATA_W-1:0]     convP0;

    // Narrow a signed accumulator value to the memory word.
    function automatic logic [DATA_W-1:0] convertResult(input logic signed [ACC_W-1:0] v);
`ifdef RESULT_SAT_EN
        logic signed [ACC_W-1:0] maxV;
        logic signed [ACC_W-1:0] minV;
        maxV = {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
        minV = {{(ACC_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};
        if (v > maxV)
            return maxV[DATA_W-1:0];
        else if (v < minV)
            return minV[DATA_W-1:0];
        else
            return v[DATA_W-1:0];
`else
        return v[DATA_W-1:0];
`endif
    endfunction

    assign full       = (occ == OCC_FULL);
    assign empty      = (occ == '0);
    assign res_ready  = (state == RUN) && !full && (acceptCnt < TOTAL);
    assign weC        = ((state == RUN) || (state == DRAIN)) && !empty;
    assign push       = res_valid && res_ready;
    assign pop        = weC && mem_gnt;
    assign acceptNext = acceptCnt + CNT_W'(push);
    assign wrNext     = wrIdx + CNT_W'(pop);

    // Stage p0: conversion happens on the way into the buffer
    assign convP0     = convertResult(res_data);

    assign addrC      = C_BASE + wrIdx[7:0];
    assign dataC      = fifoMem[rdPtr];
    assign Busy       = (state == RUN) || (state == DRAIN);
    assign Done       = (state == DONE);
    assign count      = wrIdx[7:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wrPtr     <= '0;
            rdPtr     <= '0;
            occ       <= '0;
            acceptCnt <= '0;
            wrIdx     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                fifoMem[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        state     <= RUN;
                        wrPtr     <= '0;
                        rdPtr     <= '0;
                        occ       <= '0;
                        acceptCnt <= '0;
                        wrIdx     <= '0;
                    end
                end
                RUN, DRAIN: begin
                    if (push) begin
                        fifoMem[wrPtr] <= convP0;
                        wrPtr          <= wrPtr + PTR_W'(1);
                    end
                    if (pop)
                        rdPtr <= rdPtr + PTR_W'(1);
                    case ({push, pop})
                        2'b10:   occ <= occ + (PTR_W + 1)'(1);
                        2'b01:   occ <= occ - (PTR_W + 1)'(1);
                        default: occ <= occ;
                    endcase
                    acceptCnt <= acceptNext;
                    wrIdx     <= wrNext;
                    // Last accept and last write on the same edge skip DRAIN entirely
                    if (wrNext == TOTAL)
                        state <= DONE;
                    else if ((state == RUN) && (acceptNext == TOTAL))
                        state <= DRAIN;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/c_result_writer.md
# c_result_writer

- Write-back end of the matrix-multiply datapath; counterpart to the A/B read-address generator.
- Accepts a stream of N×N dot-product results from the MAC array over a valid/ready handshake and buffers them in a small FIFO.
- Converts each result to memory data width, generates row-major write addresses for matrix C, and issues writes to the data memory under a grant handshake.
- Pulses Done when the whole C matrix is written.

## Interface
- N, 8, matrix dimension; legal 2..16.
- ACC_W, 20, width of incoming signed accumulator results.
- DATA_W, 16, width of memory data word; must be less than ACC_W.
- C_BASE, 8'd128, base address of C in data memory.
- FIFO_DEPTH, 4, result buffer entries; power of 2, at least 2.

- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- Start  in  1  begin a new C matrix; sampled only in IDLE.
- res_valid  in  1  result present on res_data.
- res_data  in  ACC_W  signed result, row-major order.
- res_ready  out  1  block accepts a result this cycle.
- mem_gnt  in  1  memory accepts the write this cycle.
- weC  out  1  write request.
- addrC  out  8  write address.
- dataC  out  DATA_W  write data.
- Busy  out  1  high in RUN and DRAIN.
- Done  out  1  one-cycle completion pulse.
- count  out  8  writes completed for the current matrix.

## Operation
States and transitions:
- IDLE: Start → RUN; clears counters and FIFO.
- RUN: accepts and writes results. After N*N accepts → DRAIN.
- DRAIN: writes only, res_ready=0. After N*N writes → DONE.
  - If the last accept and last write coincide, go RUN → DONE directly.
- DONE: Done=1 for one cycle → IDLE.
- Start is ignored in RUN, DRAIN and DONE.

Handshakes:
- Push: res_valid && res_ready.
- res_ready = (state==RUN) && !full && (accepted < N*N). It depends only on registered state; a pop in the same cycle does not raise it.
- Write request: weC = (state RUN or DRAIN) && !empty.
- addrC = C_BASE + wr_idx, where wr_idx is a linear counter 0..N*N-1. Arithmetic is mod 256 (wraps).
- dataC = FIFO head.
- Write completes on weC && mem_gnt: pop the FIFO, increment wr_idx and count.
- With weC=0, addrC/dataC are don't-care for the memory; the bench checks them only when weC=1.

Data conversion:
- Applied at push. The FIFO stores DATA_W bits.
- See Configuration for the conversion rule.

Boundary conditions:
- Full: res_ready=0; res_valid may stay high, and nothing is dropped.
- Empty: weC=0.
- Push and pop in the same cycle when neither empty nor full: occupancy unchanged.
- Push into an empty FIFO: weC rises the next cycle.
- reset mid-operation: everything returns to reset values in the next cycle. There is no partial completion and no Done pulse.

## Timing
Reset values:
- res_ready=0, weC=0, Busy=0, Done=0, count=0.
- addrC=C_BASE.
- dataC=0 (FIFO storage cleared).

Cycle behaviour:
- Start sampled at edge t → state=RUN, Busy=1, res_ready=1 after edge t.
- Push at edge t → weC=1 after edge t (minimum latency 1 cycle).
- With mem_gnt tied high and res_valid continuous: one write per cycle, sustained.
- Last write handshake at edge t → Done=1 and Busy=0 after edge t. Done=0 and state IDLE after edge t+1.
- count increments at each write handshake and holds its final value in IDLE until the next Start.

## Configuration
Macro: RESULT_SAT_EN.
- Defined: res_data is clamped as signed to the range -2^(DATA_W-1) to 2^(DATA_W-1)-1.
- Undefined: dataC is res_data[DATA_W-1:0] (plain truncation).
- Nothing else changes.

## Test plan
- Nominal streaming:
  - Stimulus: defaults; Start; 64 results with values 0..63; res_valid continuous; mem_gnt=1.
  - Required: 64 writes; addrC 128..191; dataC equal to index; Done one cycle after last write; count=64; no Done on any other cycle.
- Backpressure:
  - Stimulus: mem_gnt=0 for 10 cycles with res_valid held.
  - Required: exactly 4 accepts, then res_ready=0. When mem_gnt returns, writes are in original order, with no loss or duplication.
- Conversion:
  - res_data=20'h09000: with the macro dataC=16'h7FFF; without it 16'h9000.
  - res_data=20'hF0000: with the macro 16'h8000; without it 16'h0000.
- Reset mid-operation:
  - Stimulus: assert reset after 20 writes.
  - Required: next cycle all outputs at reset values; no Done. A new Start restarts at addrC=128 with count=0.
- Start ignored:
  - Stimulus: Start pulses during RUN, DRAIN and the DONE cycle.
  - Required: no counter or FIFO disturbance; exactly 64 writes.
- Address wrap:
  - Stimulus: C_BASE=8'd224, N=8.
  - Required: addrC runs 224..255, then 0..31; Done after 64 writes.
